// File: rtl/ones_comp_serial_ctrl.sv
// Bit-serial ones' complement add/subtract on one full-adder slice, with the
// end-around carry applied as a second serial pass. Optional macro: NEG_ZERO_NORM_EN.
module ones_comp_serial_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             wrapped,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, ADD, WRAP, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] op_a_q;
   logic [WIDTH-1:0] op_b_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             wrapped_q;
   logic [CW-1:0]    cnt_q;

   logic             fa_a;
   logic             fa_b;
   logic             fa_s;
   logic             fa_co;
   logic             last_bit;
   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] result_d;

   // The single full adder is shared: operand bits in ADD, partial sum plus carry in WRAP.
   always_comb begin
      fa_a     = (state_q == WRAP) ? sum_q[0] : op_a_q[0];
      fa_b     = (state_q == WRAP) ? 1'b0     : op_b_q[0];
      fa_s     = fa_a ^ fa_b ^ carry_q;
      fa_co    = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
      sum_d    = {fa_s, sum_q[WIDTH-1:1]};
      last_bit = (cnt_q == CW'(WIDTH - 1));
      result_d = sum_d;
`ifdef NEG_ZERO_NORM_EN
      if (&sum_d) result_d = '0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         op_a_q    <= '0;
         op_b_q    <= '0;
         sum_q     <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         wrapped_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_a_q    <= a;
                  op_b_q    <= op ? ~b : b;
                  sum_q     <= '0;
                  carry_q   <= 1'b0;
                  cnt_q     <= '0;
                  wrapped_q <= 1'b0;
                  state_q   <= ADD;
               end
            end
            ADD: begin
               sum_q   <= sum_d;
               op_a_q  <= op_a_q >> 1;
               op_b_q  <= op_b_q >> 1;
               carry_q <= fa_co;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  if (fa_co) begin
                     carry_q   <= 1'b1;
                     cnt_q     <= '0;
                     wrapped_q <= 1'b1;
                     state_q   <= WRAP;
                  end else begin
                     result_q <= result_d;
                     state_q  <= DONE;
                  end
               end
            end
            WRAP: begin
               // Carry out of this pass is impossible for valid operands and is dropped.
               sum_q   <= sum_d;
               carry_q <= fa_co;
               cnt_q   <= cnt_q + 1'b1;
               if (last_bit) begin
                  result_q <= result_d;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign wrapped = wrapped_q;
   assign result  = result_q;

endmodule

// File: tb/tb_ones_comp_serial_ctrl.sv
// Directed and back-to-back bench for ones_comp_serial_ctrl (WIDTH=4); honours NEG_ZERO_NORM_EN.
module tb_ones_comp_serial_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         wrapped;
   logic [W-1:0] result;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [W-1:0] ca, cb, neg_zero_exp;
   logic         co;
   logic [W:0]   m;
   int           n, acc_prev;

   always #5 clk = ~clk;

   ones_comp_serial_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .wrapped (wrapped),
      .result  (result)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference ones' complement sum; returns {end_around_carry, result}.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic o);
      logic [W-1:0] yy;
      logic [W:0]   s;
      logic [W-1:0] r;
      yy = o ? ~y : y;
      s  = {1'b0, x} + {1'b0, yy};
      r  = s[W-1:0] + W'(s[W]);
`ifdef NEG_ZERO_NORM_EN
      if (&r) r = '0;
`endif
      return {s[W], r};
   endfunction

   task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xo, input logic [W-1:0] er, input logic ew,
                         input int elat, input int repulse);
      int k;
      a = xa; b = xb; op = xo; start = 1'b1;
      tick;
      start = 1'b0;
      k = 1;
      check({tag, "_busy"}, int'(busy), 1);
      while (!done && k < 60) begin
         if (k == repulse) begin
            start = 1'b1; a = ~xa; b = ~xb; op = ~xo;
         end else begin
            start = 1'b0;
         end
         tick;
         k++;
      end
      start = 1'b0;
      check({tag, "_lat"}, k, elat);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_result"}, int'(result), int'(er));
      check({tag, "_wrapped"}, int'(wrapped), int'(ew));
      check({tag, "_busy_done"}, int'(busy), 1);
      tick;
      check({tag, "_pulse"}, int'(done), 0);
      check({tag, "_idle"}, int'(busy), 0);
      check({tag, "_held"}, int'(result), int'(er));
      tick;
      check({tag, "_noqueue"}, int'(busy), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
      tick;
      tick;
      reset = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_wrapped", int'(wrapped), 0);

`ifdef NEG_ZERO_NORM_EN
      neg_zero_exp = 4'b0000;
`else
      neg_zero_exp = 4'b1111;
`endif

      run_op("add_nowrap", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 5, 0);
      run_op("add_wrap",   4'b0110, 4'b1101, 1'b0, 4'b0100, 1'b1, 9, 0);
      run_op("sub_negzero", 4'b0101, 4'b0101, 1'b1, neg_zero_exp, 1'b0, 5, 0);
      run_op("sub_wrap",   4'b0110, 4'b0010, 1'b1, 4'b0100, 1'b1, 9, 0);
      run_op("add_negzero", 4'b1111, 4'b0000, 1'b0, neg_zero_exp, 1'b0, 5, 0);

      // Abort an operation mid-pass; the partial sum must never surface.
      run_op("pre_abort", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 5, 0);
      a = 4'b0110; b = 4'b1101; op = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_result", int'(result), 0);
      check("abort_wrapped", int'(wrapped), 0);
      tick;
      check("abort_stay_idle", int'(busy), 0);

      run_op("fresh", 4'b0110, 4'b1101, 1'b0, 4'b0100, 1'b1, 9, 2);
      run_op("fresh2", 4'b0001, 4'b0100, 1'b0, 4'b0101, 1'b0, 5, 3);

      // start held high; operand inputs are scrambled while busy.
      ca = 4'($urandom_range(0, 15)); cb = 4'($urandom_range(0, 15)); co = 1'($urandom_range(0, 1));
      a = ca; b = cb; op = co; start = 1'b1;
      tick;
      acc_prev = cyc;
      for (int k = 0; k < 8; k++) begin
         m = model(ca, cb, co);
         n = 1;
         while (!done && n < 60) begin
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            op = 1'($urandom_range(0, 1));
            tick;
            n++;
         end
         check("b2b_lat", n, m[W] ? 9 : 5);
         check("b2b_done", int'(done), 1);
         check("b2b_result", int'(result), int'(m[W-1:0]));
         check("b2b_wrapped", int'(wrapped), int'(m[W]));
         ca = 4'($urandom_range(0, 15)); cb = 4'($urandom_range(0, 15)); co = 1'($urandom_range(0, 1));
         a = ca; b = cb; op = co;
         tick;
         check("b2b_pulse", int'(done), 0);
         check("b2b_idle", int'(busy), 0);
         if (k < 7) begin
            tick;
            check("b2b_spacing", cyc - acc_prev, m[W] ? 10 : 6);
            acc_prev = cyc;
         end
      end
      start = 1'b0;
      tick;
      check("final_idle", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ones_comp_serial_ctrl.md
Name: ones_comp_serial_ctrl

Overview:
Sequencer that runs a ones' complement add/subtract on a single 1-bit full-adder slice, bit-serially, with the end-around carry handled as a second serial pass.
- Trades the WIDTH-stage ripple chain plus the WIDTH-stage carry-wrap chain for one full adder and a small FSM.
- Sits between switch/button operand capture and the display/result register in the lab datapath.
- Owns operand shift registers, bit counter, carry flop and the done handshake.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2..16).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = A+B, 1 = A-B (B bitwise-inverted at load).
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; result is valid in that cycle.
wrapped  output  1  end-around carry pass occurred for the last operation.
result  output  WIDTH  ones' complement result; held until the next accepted start.

Behaviour:
- Reset: when reset=1 at a rising edge, state=IDLE, busy=0, done=0, wrapped=0, result=0, bit counter=0, carry=0. Reset wins over start and aborts any operation mid-pass. No partial result is exposed.
- States: IDLE, ADD, WRAP, DONE. The state register is the sole source of busy and done, so both are glitch-free.
- IDLE: if start=1, load opA=a, opB=(op ? ~b : b), carry=0, cnt=0, wrapped=0, then go to ADD. Otherwise stay.
- ADD: one bit per cycle, LSB first.
  - Full adder inputs: opA[0], opB[0], carry. Sum shifts into the result shift register MSB side; opA and opB shift right; carry updates; cnt increments.
  - After the bit with cnt=WIDTH-1: if carry-out=1, go to WRAP with carry=1, cnt=0, wrapped=1. Otherwise go to DONE.
- WRAP: adds carry into the partial sum bit-serially, one bit per cycle for WIDTH cycles (full adder inputs: sum bit, 0, carry). Then go to DONE.
  - A carry-out of the WRAP pass cannot occur for valid ones' complement operands and is discarded.
  - The verifier asserts it never fires.
- DONE: done=1 for exactly this cycle; result register is stable. Next state is IDLE unconditionally. start in DONE is ignored (busy=1).
- Latency: the start-accept edge is cycle 0.
  - No wrap: done high in cycle WIDTH+1.
  - Wrap: done high in cycle 2*WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy: ignored and not queued; a/b/op changes while busy have no effect.
- -0 (all ones) is a legal result and is output as-is unless the optional feature below is enabled.
- result is written only on the DONE transition. Between operations it holds the last value.

Optional Feature:
Macro NEG_ZERO_NORM_EN.
- Defined: in DONE, a result of all ones (-0) is replaced by all zeros (+0) before presentation; wrapped is unaffected; latency is unchanged.
- Undefined: -0 is passed through unchanged; no comparator logic is synthesized.

Test Plan:
- WIDTH=4, reset 2 cycles, then check: busy=0, done=0, result=0000, wrapped=0.
- a=0011, b=0010, op=0, start 1 cycle -> done in cycle 5, result=0101, wrapped=0.
- a=0110, b=1101 (6 + -2), op=0 -> done in cycle 9, result=0100, wrapped=1.
- a=0101, b=0101, op=1 -> result=1111 (no macro) or 0000 (NEG_ZERO_NORM_EN), wrapped=0, done in cycle 5.
- start with a=0110, b=1101; assert reset in cycle 3 -> next cycle IDLE, busy=0, result=0000. A fresh start then completes normally; start re-pulsed while busy is ignored.
- Back-to-back: start asserted continuously -> accepts exactly every 6 cycles (no wrap). Every done is a single-cycle pulse, and result matches a reference ones' complement model over random operands.
